// File: rtl/segre_pkg.sv
// Shared types and defaults for the segre memory-side blocks.
//   ADDR_SIZE / LINE_SIZE   : cache-to-memory request field widths
//   MEM_ARB_CH              : default number of memory arbiter channels
//   ARB_BUF_SIZE / PTR_SIZE : default arbiter request FIFO depth / pointer width
//   ARB_MAX_OUTST           : default issued-but-unanswered request limit
package segre_pkg;

  localparam int unsigned ADDR_SIZE     = 32;
  localparam int unsigned LINE_SIZE     = 128;

  localparam int unsigned MEM_ARB_CH    = 2;
  localparam int unsigned ARB_MAX_OUTST = 16;
  localparam int unsigned ARB_BUF_SIZE  = 16;
  localparam int unsigned ARB_PTR_SIZE  = $clog2(ARB_BUF_SIZE);
  localparam int unsigned ARB_CH_W      = $clog2(MEM_ARB_CH);

  // Channel index of each L1 cache on the memory arbiter
  typedef enum logic [ARB_CH_W-1:0] {
    ICACHE = ARB_CH_W'(0),
    DCACHE = ARB_CH_W'(1)
  } cache_id_e;

  // Cache line request towards main memory
  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] line;
  } cache_mem_req_t;

  // Arbiter request FIFO entry for the default two-channel configuration;
  // the top packs its entries in this same field order for any NUM_CH.
  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] line;
    cache_id_e            ch;
  } mem_arb_entry_t;

endpackage

// File: rtl/segre_sync_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk_i, rsn_i : clock, asynchronous active-low reset (pointers/count only)
//   push_i/data_i: write port, ignored when full
//   pop_i/data_o : read port, data_o shows the head, pop ignored when empty
//   full_o, empty_o, count_o : occupancy status (count is $clog2(DEPTH)+1 bits)
module segre_sync_fifo
  import segre_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = ARB_BUF_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr];

  // Storage: no reset, contents are only observed through valid entries
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// N-channel round-robin memory arbiter.
//   req_*    : per-channel cache line requests (valid/ready, one grant per cycle)
//   mem_*    : in-order request issue to main memory (valid/ready) from FIFO head
//   mem_rsp_*: in-order memory responses, one per issued request
//   rsp_*    : registered one-hot response strobe and shared response line
//   busy_o   : registered, queue or outstanding requests present last cycle
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned NUM_CH    = MEM_ARB_CH,
  parameter int unsigned DEPTH     = ARB_BUF_SIZE,
  parameter int unsigned MAX_OUTST = ARB_MAX_OUTST,
  parameter int unsigned ADDR_W    = ADDR_SIZE,
  parameter int unsigned LINE_W    = LINE_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rsn_i,
  input  logic [NUM_CH-1:0]          req_valid_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  input  logic [NUM_CH-1:0]          req_rd_i,
  input  logic [NUM_CH-1:0]          req_wr_i,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_CH*LINE_W-1:0]   req_line_i,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic                       mem_rd_o,
  output logic                       mem_wr_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [LINE_W-1:0]          mem_line_o,
  output logic [$clog2(NUM_CH)-1:0]  mem_ch_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [LINE_W-1:0]          mem_rsp_line_i,
  output logic [NUM_CH-1:0]          rsp_valid_o,
  output logic [LINE_W-1:0]          rsp_line_o,
  output logic                       busy_o
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned ENT_W = 2 + ADDR_W + LINE_W + CH_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OST_W = $clog2(MAX_OUTST) + 1;

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W:0]    rr_idx;
  logic [CH_W-1:0]  grant_ch;
  logic             grant_any;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] head_ent;
  logic             req_full;
  logic             req_empty;
  logic [CNT_W-1:0] req_count;
  logic             id_full;
  logic             id_empty;
  logic [OST_W-1:0] id_count;
  logic [CH_W-1:0]  id_head;
  logic             issue;
  logic             rsp_take;

  // Round-robin search: first valid channel at or after rr_ptr, with wrap.
  // Gated by rsn_i so req_ready_o drops as soon as reset asserts.
  always_comb begin
    grant_ch    = '0;
    grant_any   = 1'b0;
    rr_idx      = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rr_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (rr_idx >= (CH_W+1)'(NUM_CH)) rr_idx = rr_idx - (CH_W+1)'(NUM_CH);
      if (!grant_any && req_valid_i[rr_idx[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_ch  = rr_idx[CH_W-1:0];
      end
    end
    if (req_full || !rsn_i) grant_any = 1'b0;
    if (grant_any) req_ready_o[grant_ch] = 1'b1;
  end

  assign push_ent = {req_rd_i[grant_ch], req_wr_i[grant_ch],
                     req_addr_i[grant_ch*ADDR_W +: ADDR_W],
                     req_line_i[grant_ch*LINE_W +: LINE_W],
                     grant_ch};

  segre_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (grant_any),
    .data_i  (push_ent),
    .pop_i   (issue),
    .data_o  (head_ent),
    .full_o  (req_full),
    .empty_o (req_empty),
    .count_o (req_count)
  );

  // Issue from the FIFO head while the outstanding window has room.
  // Data fields read zero whenever nothing is being offered.
  assign mem_valid_o = !req_empty && !id_full;
  assign issue       = mem_valid_o && mem_ready_i;
  assign {mem_rd_o, mem_wr_o, mem_addr_o, mem_line_o, mem_ch_o} =
         mem_valid_o ? head_ent : '0;

  // Responses with nothing outstanding (e.g. for requests dropped by reset) are ignored
  assign rsp_take = mem_rsp_valid_i && !id_empty;

  // Channel IDs of issued requests, in issue order; its count is the outstanding count
  segre_sync_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (issue),
    .data_i  (head_ent[CH_W-1:0]),
    .pop_i   (rsp_take),
    .data_o  (id_head),
    .full_o  (id_full),
    .empty_o (id_empty),
    .count_o (id_count)
  );

  // Round-robin pointer, response routing and busy flag
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rr_ptr      <= '0;
      rsp_valid_o <= '0;
      rsp_line_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end
      rsp_valid_o <= rsp_take ? (NUM_CH'(1) << id_head) : '0;
      if (rsp_take) rsp_line_o <= mem_rsp_line_i;
      busy_o <= (req_count != '0) || (id_count != '0);
    end
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter (4 channels, 16-deep FIFO, 4 outstanding).
// Reference model: a queue of pending requests, a queue of outstanding channel IDs
// and a "next preferred channel" index, advanced once per clock edge.
module tb_segre_mem_arbiter;

  localparam int NCH  = 4;
  localparam int DEP  = 16;
  localparam int MOUT = 4;
  localparam int AW   = 32;
  localparam int LW   = 128;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rsn;
  logic [NCH-1:0]    v_valid, v_rd, v_wr;
  logic [NCH*AW-1:0] v_addr;
  logic [NCH*LW-1:0] v_line;
  logic              mem_ready, rsp_v;
  logic [LW-1:0]     rsp_l;

  logic [NCH-1:0]    req_ready, rsp_valid;
  logic              mem_valid, mem_rd, mem_wr, busy;
  logic [AW-1:0]     mem_addr;
  logic [LW-1:0]     mem_line, rsp_line;
  logic [CW-1:0]     mem_ch;

  always #5 clk = ~clk;

  segre_mem_arbiter #(
    .NUM_CH(NCH), .DEPTH(DEP), .MAX_OUTST(MOUT), .ADDR_W(AW), .LINE_W(LW)
  ) dut (
    .clk_i           (clk),
    .rsn_i           (rsn),
    .req_valid_i     (v_valid),
    .req_ready_o     (req_ready),
    .req_rd_i        (v_rd),
    .req_wr_i        (v_wr),
    .req_addr_i      (v_addr),
    .req_line_i      (v_line),
    .mem_valid_o     (mem_valid),
    .mem_ready_i     (mem_ready),
    .mem_rd_o        (mem_rd),
    .mem_wr_o        (mem_wr),
    .mem_addr_o      (mem_addr),
    .mem_line_o      (mem_line),
    .mem_ch_o        (mem_ch),
    .mem_rsp_valid_i (rsp_v),
    .mem_rsp_line_i  (rsp_l),
    .rsp_valid_o     (rsp_valid),
    .rsp_line_o      (rsp_line),
    .busy_o          (busy)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
    int            ch;
  } req_t;

  req_t mq[$];
  int   mid[$];
  int   m_rr;

  logic [NCH-1:0] e_ready, o_ready, e_rsp, o_rsp;
  logic           e_mv, o_mv, e_busy, o_busy;
  req_t           e_head;
  logic           o_rd, o_wr;
  logic [AW-1:0]  o_addr;
  logic [LW-1:0]  o_mline, e_line, o_line;
  logic [CW-1:0]  o_ch;
  int             total, bad;

  function automatic logic [AW+LW+CW+1:0] head_vec(input req_t r);
    return {r.rd, r.wr, r.addr, r.line, CW'(r.ch)};
  endfunction

  task automatic set_ch(input int c, input logic v, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [LW-1:0] l);
    v_valid[c] = v; v_rd[c] = rd; v_wr[c] = wr;
    v_addr[c*AW +: AW] = a; v_line[c*LW +: LW] = l;
  endtask

  task automatic model_reset();
    mq.delete(); mid.delete();
    m_rr = 0; e_rsp = '0; e_line = '0; e_busy = 1'b0;
  endtask

  // One clock: predict/sample combinational outputs, advance model at the edge,
  // then sample registered outputs at the following falling edge.
  task automatic tick();
    int   g, tmp;
    req_t ent;
    g = -1;
    if (mq.size() < DEP)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && v_valid[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    e_mv = (mq.size() > 0) && (mid.size() < MOUT);
    if (e_mv) e_head = mq[0];
    #1;
    o_ready = req_ready; o_mv = mem_valid; o_rd = mem_rd; o_wr = mem_wr;
    o_addr = mem_addr; o_mline = mem_line; o_ch = mem_ch;
    @(posedge clk);
    e_busy = (mq.size() != 0) || (mid.size() != 0);
    e_rsp  = '0;
    if (rsp_v && mid.size() > 0) begin
      tmp = mid.pop_front();
      e_rsp[tmp] = 1'b1;
      e_line = rsp_l;
    end
    if (e_mv && mem_ready) begin
      mid.push_back(mq[0].ch);
      ent = mq.pop_front();
    end
    if (g >= 0) begin
      ent.rd = v_rd[g]; ent.wr = v_wr[g];
      ent.addr = v_addr[g*AW +: AW]; ent.line = v_line[g*LW +: LW]; ent.ch = g;
      mq.push_back(ent);
      m_rr = (g + 1) % NCH;
    end
    @(negedge clk);
    o_rsp = rsp_valid; o_line = rsp_line; o_busy = busy;
  endtask

  task automatic drain();
    v_valid = '0; mem_ready = 1'b1; rsp_v = 1'b1;
    for (int i = 0; i < 200 && (mq.size() != 0 || mid.size() != 0); i++) tick();
    rsp_v = 1'b0;
    tick(); tick();
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_reset();
    rsn = 1'b0; v_valid = '1; v_rd = '0; v_wr = '0; v_addr = '0; v_line = '0;
    mem_ready = 1'b0; rsp_v = 1'b0; rsp_l = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b exp=0", mem_valid); end
    total++; if (rsp_valid !== '0 || rsp_line !== '0) begin bad++; $display("FAIL reset_rsp got=%b/%h exp=0", rsp_valid, rsp_line); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    v_valid = '0; rsn = 1'b1;
  endtask

  task automatic test_single_read();
    logic [LW-1:0] dl;
    dl = {4{32'hDEAD_BEEF}};
    mem_ready = 1'b1; rsp_v = 1'b0;
    set_ch(1, 1'b1, 1'b1, 1'b0, 32'h100, '0);
    tick();
    total++; if (o_ready !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b exp=0010", o_ready); end
    set_ch(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    total++;
    if (o_mv !== 1'b1 || o_ch !== 2'd1 || o_addr !== 32'h100 || o_rd !== 1'b1 || o_wr !== 1'b0) begin
      bad++; $display("FAIL single_issue got=v%b ch%0d a%h rd%b wr%b exp=v1 ch1 a100 rd1 wr0", o_mv, o_ch, o_addr, o_rd, o_wr);
    end
    tick();
    rsp_v = 1'b1; rsp_l = dl;
    tick();
    total++;
    if (o_rsp !== 4'b0010 || o_line !== dl) begin
      bad++; $display("FAIL single_rsp got=%b %h exp=0010 %h", o_rsp, o_line, dl);
    end
    rsp_v = 1'b0; rsp_l = '0;
    tick();
    total++;
    if (o_rsp !== 4'b0000 || o_line !== dl || o_busy !== 1'b0) begin
      bad++; $display("FAIL single_after got=%b %h busy%b exp=0000 %h busy0", o_rsp, o_line, o_busy, dl);
    end
  endtask

  task automatic test_round_robin();
    int start, n, exp_ch;
    logic [NCH-1:0] x;
    start = m_rr; n = 0;
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 1'b1, 1'b0, 32'h2000 + c * 32'h40, {4{$urandom}});
    mem_ready = 1'b1; rsp_v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL rr_model got=%b exp=%b", o_ready, e_ready); end
      if (o_ready != '0) begin
        exp_ch = (start + n) % NCH;
        x = '0; x[exp_ch] = 1'b1;
        total++; if (o_ready !== x) begin bad++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, o_ready, x); end
        n++;
      end
    end
    total++; if (n != 16) begin bad++; $display("FAIL rr_count got=%0d exp=16", n); end
    drain();
  endtask

  task automatic test_fifo_full();
    int k, n;
    mem_ready = 1'b0; rsp_v = 1'b0; k = 0;
    set_ch(0, 1'b1, 1'b1, 1'b0, 32'h1000, '0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_ready[0]) begin k++; set_ch(0, 1'b1, 1'b1, 1'b0, 32'h1000 + k * 32'h40, '0); end
      if (i > 0) begin
        total++;
        if (o_mv !== 1'b1 || o_addr !== 32'h1000) begin bad++; $display("FAIL full_head i=%0d got=v%b a%h exp=v1 a1000", i, o_mv, o_addr); end
      end
    end
    total++; if (k != DEP) begin bad++; $display("FAIL full_accepted got=%0d exp=%0d", k, DEP); end
    total++; if (o_ready !== '0) begin bad++; $display("FAIL full_ready got=%b exp=0", o_ready); end
    v_valid = '0; mem_ready = 1'b1; rsp_v = 1'b1; n = 0;
    for (int i = 0; i < 60 && n < DEP; i++) begin
      tick();
      if (o_mv) begin
        total++;
        if (o_addr !== 32'h1000 + n * 32'h40) begin bad++; $display("FAIL full_drain n=%0d got=%h exp=%h", n, o_addr, 32'h1000 + n * 32'h40); end
        n++;
      end
    end
    total++; if (n != DEP) begin bad++; $display("FAIL full_drain_count got=%0d exp=%0d", n, DEP); end
    drain();
  endtask

  task automatic test_max_outst();
    int hs;
    mem_ready = 1'b1; rsp_v = 1'b0; hs = 0;
    for (int i = 0; i < 16; i++) begin
      set_ch(2, (i < 6), 1'b1, 1'b0, 32'h3000 + i * 32'h40, '0);
      tick();
      if (o_mv) hs++;
    end
    total++; if (hs != MOUT) begin bad++; $display("FAIL outst_limit got=%0d exp=%0d", hs, MOUT); end
    total++; if (o_mv !== 1'b0) begin bad++; $display("FAIL outst_mvalid got=%b exp=0", o_mv); end
    rsp_v = 1'b1; rsp_l = 128'h5;
    tick();
    rsp_v = 1'b0; hs = 0;
    total++; if (o_rsp !== 4'b0100) begin bad++; $display("FAIL outst_rsp got=%b exp=0100", o_rsp); end
    for (int i = 0; i < 6; i++) begin tick(); if (o_mv) hs++; end
    total++; if (hs != 1) begin bad++; $display("FAIL outst_one_more got=%0d exp=1", hs); end
    drain();
  endtask

  task automatic test_interleave();
    logic [LW-1:0]  lines [3];
    logic [NCH-1:0] seq [3];
    logic [LW-1:0]  wl;
    seq = '{4'b0001, 4'b0010, 4'b0001};
    for (int j = 0; j < 3; j++) lines[j] = {$urandom, $urandom, $urandom, $urandom};
    wl = {4{32'hA5A5_0F0F}};
    mem_ready = 1'b1; rsp_v = 1'b0;
    set_ch(0, 1'b1, 1'b1, 1'b0, 32'h500, '0);
    tick();
    set_ch(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_ch(1, 1'b1, 1'b0, 1'b1, 32'h540, wl);
    tick();
    set_ch(1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_ch(0, 1'b1, 1'b1, 1'b0, 32'h580, '0);
    tick();
    total++;
    if (o_mv !== 1'b1 || o_ch !== 2'd1 || o_wr !== 1'b1 || o_rd !== 1'b0 || o_addr !== 32'h540 || o_mline !== wl) begin
      bad++; $display("FAIL ilv_write got=v%b ch%0d rd%b wr%b a%h exp=v1 ch1 rd0 wr1 a540", o_mv, o_ch, o_rd, o_wr, o_addr);
    end
    set_ch(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    for (int j = 0; j < 3; j++) begin
      rsp_v = 1'b1; rsp_l = lines[j];
      tick();
      total++;
      if (o_rsp !== seq[j] || o_line !== lines[j]) begin
        bad++; $display("FAIL ilv_rsp j=%0d got=%b %h exp=%b %h", j, o_rsp, o_line, seq[j], lines[j]);
      end
    end
    rsp_v = 1'b0;
    tick();
    total++; if (o_rsp !== '0) begin bad++; $display("FAIL ilv_idle got=%b exp=0", o_rsp); end
  endtask

  task automatic test_reset_midflight();
    drain();
    mem_ready = 1'b1; rsp_v = 1'b0;
    set_ch(3, 1'b1, 1'b1, 1'b0, 32'h4000, '0); tick();
    set_ch(3, 1'b1, 1'b1, 1'b0, 32'h4040, '0); tick();
    set_ch(3, 1'b0, 1'b0, 1'b0, '0, '0);       tick();
    mem_ready = 1'b0;
    set_ch(3, 1'b1, 1'b1, 1'b0, 32'h4080, '0);
    tick(); tick(); tick();
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rstm_busy_before got=%b exp=1", o_busy); end
    #2 rsn = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || mem_valid !== 1'b0 || mem_addr !== '0 || mem_ch !== '0) begin
      bad++; $display("FAIL rstm_req got=r%b v%b a%h exp=0", req_ready, mem_valid, mem_addr);
    end
    total++;
    if (rsp_valid !== '0 || rsp_line !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstm_rsp got=%b %h busy%b exp=0", rsp_valid, rsp_line, busy);
    end
    model_reset();
    @(negedge clk);
    set_ch(3, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rsn = 1'b1;
    rsp_v = 1'b1; rsp_l = '1;
    tick();
    total++; if (o_rsp !== '0) begin bad++; $display("FAIL rstm_stray got=%b exp=0", o_rsp); end
    rsp_v = 1'b0;
    tick();
    total++;
    if (o_rsp !== '0 || o_busy !== 1'b0 || o_mv !== 1'b0 || o_line !== '0) begin
      bad++; $display("FAIL rstm_after got=%b busy%b v%b %h exp=0", o_rsp, o_busy, o_mv, o_line);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        set_ch(c, ($urandom_range(0, 1) == 1), 1'($urandom), 1'($urandom), $urandom,
               {$urandom, $urandom, $urandom, $urandom});
      mem_ready = ($urandom_range(0, 9) < 6);
      rsp_v     = ($urandom_range(0, 9) < 4);
      rsp_l     = {$urandom, $urandom, $urandom, $urandom};
      tick();
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, o_ready, e_ready); end
      total++; if (o_mv !== e_mv) begin bad++; $display("FAIL rnd_mvalid i=%0d got=%b exp=%b", i, o_mv, e_mv); end
      if (e_mv && o_mv) begin
        total++;
        if ({o_rd, o_wr, o_addr, o_mline, o_ch} !== head_vec(e_head)) begin
          bad++; $display("FAIL rnd_head i=%0d got=%h exp=%h", i, {o_rd, o_wr, o_addr, o_mline, o_ch}, head_vec(e_head));
        end
      end
      total++; if (o_rsp !== e_rsp) begin bad++; $display("FAIL rnd_rsp i=%0d got=%b exp=%b", i, o_rsp, e_rsp); end
      total++; if (o_line !== e_line) begin bad++; $display("FAIL rnd_line i=%0d got=%h exp=%h", i, o_line, e_line); end
      total++; if (o_busy !== e_busy) begin bad++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, o_busy, e_busy); end
    end
    drain();
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fifo_full();
    test_max_outst();
    test_interleave();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
